// File: rtl/uart_rx_axis_fifo.sv
// UART receiver with configurable frame format, per-word error flags and an
// AXI-Stream master output fed from a first-word-fall-through FIFO.
module uart_rx_axis_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_rxd,
   input  logic                          i_m_axis_tready,
   output logic                          o_m_axis_tvalid,
   output logic [DATA_BITS-1:0]          o_m_axis_tdata,
   output logic [1:0]                    o_m_axis_tuser,
   output logic                          o_rxd_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_lvl,
   output logic                          o_overflow,
   input  logic                          i_clr_overflow
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = DATA_BITS + 2;

   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_WAIT_HIGH,
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- input
   logic rxd_meta_q, rxd_s_q, rxd_prev_q;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= i_rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q;
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic                   stop_q, stop_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   ferr_now;
   logic                   expire;
   logic                   push;
   logic [WW-1:0]          push_word;

   assign expire = (cnt_q == CW'(1));

   // Receiver state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_WAIT_HIGH;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic: every bit is sampled when the baud counter expires.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      data_d    = data_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ferr_now  = ferr_q | ~rxd_s_q;
      push      = 1'b0;
      push_word = {perr_q, ferr_now, data_q};
      if (state_q != S_WAIT_HIGH && state_q != S_IDLE && !expire)
         cnt_d = cnt_q - CW'(1);
      unique case (state_q)
         S_WAIT_HIGH: begin
            if (rxd_s_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (rxd_prev_q && !rxd_s_q) begin
               state_d = S_START;
               cnt_d   = HALF_BIT;
               bit_d   = '0;
               stop_d  = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: begin
            if (expire) begin
               if (!rxd_s_q) begin
                  state_d = S_DATA;
                  cnt_d   = FULL_BIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (expire) begin
               data_d = {rxd_s_q, data_q[DATA_BITS-1:1]};
               cnt_d  = FULL_BIT;
               if (bit_q == BW'(DATA_BITS - 1))
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               else
                  bit_d = bit_q + BW'(1);
            end
         end
         S_PARITY: begin
            if (expire) begin
               perr_d  = ((^data_q) ^ rxd_s_q) != (PARITY == 1);
               cnt_d   = FULL_BIT;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (expire) begin
               ferr_d = ferr_now;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
               end else begin
                  stop_d = 1'b1;
                  cnt_d  = FULL_BIT;
               end
            end
         end
         default: state_d = S_WAIT_HIGH;
      endcase
   end

   assign o_rxd_busy = (state_q != S_WAIT_HIGH) && (state_q != S_IDLE);

   // ---------------------------------------------------------------- FIFO
   logic [WW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] lvl_q;
   logic          ovf_q;
   logic          full, do_push, do_pop;
   logic [WW-1:0] head;

   assign full    = (lvl_q == LW'(FIFO_DEPTH));
   assign do_push = push && !full;
   assign do_pop  = (lvl_q != '0) && i_m_axis_tready;

   // Storage array; the head entry is never overwritten while it is visible.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_q] <= push_word;
   end

   // Pointers, occupancy and sticky overflow (a drop beats a clear).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   lvl_q <= lvl_q + LW'(1);
            2'b01:   lvl_q <= lvl_q - LW'(1);
            default: lvl_q <= lvl_q;
         endcase
         if (push && full)        ovf_q <= 1'b1;
         else if (i_clr_overflow) ovf_q <= 1'b0;
      end
   end

   assign head            = mem_q[rd_q];
   assign o_m_axis_tvalid = (lvl_q != '0);
   assign o_m_axis_tdata  = o_m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
   assign o_m_axis_tuser  = o_m_axis_tvalid ? head[WW-1 -: 2] : 2'b00;
   assign o_fifo_lvl      = lvl_q;
   assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Self-checking bench: three receiver instances (8N1 depth 32, 8E1 depth 4,
// 7O2 depth 8) driven with serial frames; received beats are compared against
// words predicted from the frame contents and the parity/stop rules.
module tb_uart_rx_axis_fifo;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // instance A: 8N1, depth 32
   logic       a_rxd = 1'b1, a_tready = 1'b1, a_clr = 1'b0;
   logic       a_tvalid, a_busy, a_ovf;
   logic [7:0] a_tdata;
   logic [1:0] a_tuser;
   logic [5:0] a_lvl;
   // instance E: 8E1, depth 4
   logic       e_rxd = 1'b1, e_tready = 1'b1, e_clr = 1'b0;
   logic       e_tvalid, e_busy, e_ovf;
   logic [7:0] e_tdata;
   logic [1:0] e_tuser;
   logic [2:0] e_lvl;
   // instance S: 7O2, depth 8
   logic       s_rxd = 1'b1, s_tready = 1'b1, s_clr = 1'b0;
   logic       s_tvalid, s_busy, s_ovf;
   logic [6:0] s_tdata;
   logic [1:0] s_tuser;
   logic [3:0] s_lvl;

   uart_rx_axis_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(32)) u_a (
      .i_clk(clk), .i_rst(rst), .i_rxd(a_rxd), .i_m_axis_tready(a_tready),
      .o_m_axis_tvalid(a_tvalid), .o_m_axis_tdata(a_tdata), .o_m_axis_tuser(a_tuser),
      .o_rxd_busy(a_busy), .o_fifo_lvl(a_lvl), .o_overflow(a_ovf), .i_clr_overflow(a_clr));

   uart_rx_axis_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
      .i_clk(clk), .i_rst(rst), .i_rxd(e_rxd), .i_m_axis_tready(e_tready),
      .o_m_axis_tvalid(e_tvalid), .o_m_axis_tdata(e_tdata), .o_m_axis_tuser(e_tuser),
      .o_rxd_busy(e_busy), .o_fifo_lvl(e_lvl), .o_overflow(e_ovf), .i_clr_overflow(e_clr));

   uart_rx_axis_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u_s (
      .i_clk(clk), .i_rst(rst), .i_rxd(s_rxd), .i_m_axis_tready(s_tready),
      .o_m_axis_tvalid(s_tvalid), .o_m_axis_tdata(s_tdata), .o_m_axis_tuser(s_tuser),
      .o_rxd_busy(s_busy), .o_fifo_lvl(s_lvl), .o_overflow(s_ovf), .i_clr_overflow(s_clr));

   // Beat capture: word = (tuser << 9) | tdata, recorded when a transfer occurs.
   int got_a[$], got_e[$], got_s[$], cyc_a[$];
   always @(negedge clk) begin
      if (!rst && a_tvalid && a_tready) begin
         got_a.push_back((int'(a_tuser) << 9) | int'(a_tdata));
         cyc_a.push_back(cyc);
      end
      if (!rst && e_tvalid && e_tready) got_e.push_back((int'(e_tuser) << 9) | int'(e_tdata));
      if (!rst && s_tvalid && s_tready) got_s.push_back((int'(s_tuser) << 9) | int'(s_tdata));
   end

   // Stall stability watcher for instance S.
   logic       s_prev_stall = 1'b0;
   logic [6:0] s_prev_d = '0;
   logic [1:0] s_prev_u = '0;
   int         s_unstable = 0;
   int         s_stalls = 0;
   always @(negedge clk) begin
      if (s_prev_stall && (!s_tvalid || s_tdata !== s_prev_d || s_tuser !== s_prev_u))
         s_unstable <= s_unstable + 1;
      if (!rst && s_tvalid && !s_tready) s_stalls <= s_stalls + 1;
      s_prev_stall <= !rst && s_tvalid && !s_tready;
      s_prev_d     <= s_tdata;
      s_prev_u     <= s_tuser;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_bit(input int u, input bit v);
      case (u)
         0:       a_rxd = v;
         1:       e_rxd = v;
         default: s_rxd = v;
      endcase
      repeat (CPB) tick();
   endtask

   // pbit < 0 means no parity bit on the line.
   task automatic send_frame(input int u, input int d, input int nbits, input int pbit,
                             input int nstop, input bit stopv);
      drive_bit(u, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(u, ((d >> i) & 1) != 0);
      if (pbit >= 0) drive_bit(u, pbit != 0);
      for (int i = 0; i < nstop; i++) drive_bit(u, stopv);
   endtask

   task automatic cmp_queue(input string name, input int got[$], input int exp[$]);
      checks++;
      if (got.size() != exp.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d want %0d", name, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (i >= got.size() || got[i] !== exp[i]) begin
            failures++;
            $display("FAIL %s_word%0d: got %0h want %0h", name, i,
                     (i < got.size()) ? got[i] : -1, exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({a_tvalid, a_busy, a_ovf, a_tdata, a_tuser, a_lvl} !== '0) begin
         failures++;
         $display("FAIL reset_a: got %0h want 0", {a_tvalid, a_busy, a_ovf, a_tdata, a_tuser, a_lvl});
      end
      checks++;
      if ({e_tvalid, e_busy, e_ovf, e_lvl, s_tvalid, s_busy, s_ovf, s_lvl} !== '0) begin
         failures++;
         $display("FAIL reset_es: got %0h want 0", {e_tvalid, e_busy, e_ovf, e_lvl, s_tvalid, s_busy, s_ovf, s_lvl});
      end
      rst = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_8n1();
      int exp[$];
      int c0, d;
      a_tready = 1'b1;
      got_a.delete(); cyc_a.delete();
      c0 = cyc;
      send_frame(0, 'hA5, 8, -1, 1, 1'b1);
      exp.push_back('hA5);
      repeat (20) tick();
      checks++;
      if (cyc_a.size() < 1 || cyc_a[0] - c0 < 9*CPB + 4 || cyc_a[0] - c0 > 9*CPB + 14) begin
         failures++;
         $display("FAIL 8n1_latency: got %0d want %0d..%0d", (cyc_a.size() > 0) ? cyc_a[0] - c0 : -1,
                  9*CPB + 4, 9*CPB + 14);
      end
      for (int i = 0; i < 4; i++) begin
         d = int'($urandom_range(0, 255));
         send_frame(0, d, 8, -1, 1, 1'b1);
         exp.push_back(d);
      end
      repeat (20) tick();
      cmp_queue("8n1", got_a, exp);
      checks++;
      if (a_busy !== 1'b0 || a_lvl !== 6'd0) begin
         failures++;
         $display("FAIL 8n1_idle: got busy=%0b lvl=%0d want 0/0", a_busy, a_lvl);
      end
   endtask

   task automatic test_parity();
      int exp[$];
      int d, p;
      e_tready = 1'b1;
      got_e.delete();
      for (int i = 0; i < 8; i++) begin
         if (i < 2) begin
            d = 'h03; p = (i == 0) ? 1 : 0;
         end else begin
            d = int'($urandom_range(0, 255)); p = int'($urandom_range(0, 1));
         end
         send_frame(1, d, 8, p, 1, 1'b1);
         // even parity: total count of ones over data+parity must be even
         exp.push_back(((($countones(d) + p) % 2) != 0 ? 2 : 0) << 9 | d);
      end
      repeat (20) tick();
      cmp_queue("8e1", got_e, exp);
   endtask

   task automatic test_break();
      int exp[$];
      int d, d2;
      a_tready = 1'b1;
      got_a.delete();
      d  = int'($urandom_range(0, 255));
      d2 = int'($urandom_range(0, 255));
      send_frame(0, d, 8, -1, 1, 1'b0);
      exp.push_back((1 << 9) | d);
      repeat (40*CPB) tick();
      checks++;
      if (a_busy !== 1'b0) begin
         failures++;
         $display("FAIL break_busy: got %0b want 0", a_busy);
      end
      a_rxd = 1'b1;
      repeat (2*CPB) tick();
      cmp_queue("break", got_a, exp);
      send_frame(0, d2, 8, -1, 1, 1'b1);
      exp.push_back(d2);
      repeat (20) tick();
      cmp_queue("break_recover", got_a, exp);
   endtask

   task automatic test_overflow();
      int exp[$];
      a_tready = 1'b0;
      got_a.delete();
      for (int i = 0; i <= 32; i++) begin
         send_frame(0, i, 8, -1, 1, 1'b1);
         if (i < 32) exp.push_back(i);
      end
      repeat (20) tick();
      checks++;
      if (a_lvl !== 6'd32 || a_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_full: got lvl=%0d ovf=%0b want 32/1", a_lvl, a_ovf);
      end
      a_tready = 1'b1;
      repeat (40) tick();
      cmp_queue("ovf_drain", got_a, exp);
      checks++;
      if (a_lvl !== 6'd0 || a_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky: got lvl=%0d ovf=%0b want 0/1", a_lvl, a_ovf);
      end
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      checks++;
      if (a_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %0b want 0", a_ovf);
      end
   endtask

   task automatic test_glitch_reset();
      bit seen = 1'b0;
      int none[$];
      a_tready = 1'b1;
      got_a.delete();
      a_rxd = 1'b0;
      tick();
      a_rxd = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (a_busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL glitch_busy: got seen=%0b busy=%0b want 1/0", seen, a_busy);
      end
      cmp_queue("glitch", got_a, none);
      a_tready = 1'b0;
      send_frame(0, 'h3C, 8, -1, 1, 1'b1);
      repeat (20) tick();
      checks++;
      if (a_lvl !== 6'd1 || a_tvalid !== 1'b1 || a_tdata !== 8'h3C) begin
         failures++;
         $display("FAIL pre_reset: got lvl=%0d v=%0b d=%0h want 1/1/3c", a_lvl, a_tvalid, a_tdata);
      end
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      rst = 1'b1;
      tick();
      checks++;
      if ({a_tvalid, a_busy, a_ovf, a_tdata, a_tuser, a_lvl} !== '0) begin
         failures++;
         $display("FAIL mid_reset: got %0h want 0", {a_tvalid, a_busy, a_ovf, a_tdata, a_tuser, a_lvl});
      end
      rst = 1'b0;
      a_rxd = 1'b1;
      a_tready = 1'b1;
      got_a.delete();
      repeat (12*CPB) tick();
      cmp_queue("post_reset", got_a, none);
   endtask

   bit rand_done;
   task automatic test_back_to_back();
      int exp[$];
      int d, p, bad;
      got_s.delete();
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               d   = (i == 0) ? 'h55 : (i == 1) ? 'h2A : int'($urandom_range(0, 127));
               bad = (i < 2) ? 0 : int'($urandom_range(0, 1));
               // odd parity: data ones plus parity bit must be odd
               p   = (($countones(d) % 2) == 0) ? 1 : 0;
               if (bad != 0) p = 1 - p;
               send_frame(2, d, 7, p, 2, 1'b1);
               exp.push_back((bad << 10) | d);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               tick();
               s_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      s_tready = 1'b1;
      repeat (40) tick();
      cmp_queue("b2b", got_s, exp);
      checks++;
      if (s_unstable !== 0 || s_lvl !== 4'd0) begin
         failures++;
         $display("FAIL b2b_stable: got unstable=%0d lvl=%0d want 0/0 (stalls=%0d)", s_unstable, s_lvl, s_stalls);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_8n1();
      test_parity();
      test_break();
      test_overflow();
      test_glitch_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
